// File: rtl/spi_slave_param.sv
// SPI mode-0 slave bridging an SPI master to a single-port RAM.
// Generic width, selectable bit order, abort detection, read timeout.
// Ports: clk, rst_n (sync, active low), SS_n, MOSI -> MISO;
//   rx_data/rx_valid frame out; tx_data/tx_valid read data in;
//   busy, frame_err, tx_timeout status.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_timeout
);

  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(DATA_W + 3);
  localparam int TW = $clog2(TX_TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(FW);
  localparam logic [CW-1:0] CNT_TX   = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [TW-1:0] TO_LAST  = TW'(TX_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_WRITE,
    S_RADD,
    S_RDATA
  } state_t;

  typedef enum logic [1:0] {
    P_RX,
    P_WAIT,
    P_TX,
    P_DONE
  } phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [FW-1:0]     rxd_q, rxd_d;
  logic              rxv_q, rxv_d;
  logic              miso_q, miso_d;
  logic              ferr_q, ferr_d;
  logic              tout_q, tout_d;
  logic              rdf_q, rdf_d;

  logic [FW-1:0]     rx_shift;
  logic              in_rx;

  assign rx_shift = LSB_FIRST ?
                    {MOSI, rxd_q[FW-1:1]} :
                    {rxd_q[FW-2:0], MOSI};

  // Frame bits are still being collected (abort here drops the frame).
  assign in_rx = (state_q == S_WRITE) ||
                 (state_q == S_RADD)  ||
                 ((state_q == S_RDATA) && (phase_q == P_RX));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    sh_d    = sh_q;
    rxd_d   = rxd_q;
    rdf_d   = rdf_q;
    rxv_d   = 1'b0;
    miso_d  = 1'b0;
    ferr_d  = 1'b0;
    tout_d  = 1'b0;

    if ((state_q != S_IDLE) && SS_n) begin
      state_d = S_IDLE;
      phase_d = P_RX;
      cnt_d   = CNT_FULL;
      if (in_rx && (cnt_q != CNT_ZERO) &&
          (cnt_q != CNT_FULL)) begin
        ferr_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          rxd_d   = '0;
          cnt_d   = CNT_FULL;
          phase_d = P_RX;
          if (!SS_n) state_d = S_CHK;
        end
        S_CHK: begin
          rxd_d   = '0;
          cnt_d   = CNT_FULL;
          phase_d = P_RX;
          to_d    = '0;
          if (!MOSI)      state_d = S_WRITE;
          else if (rdf_q) state_d = S_RDATA;
          else            state_d = S_RADD;
        end
        S_WRITE, S_RADD: begin
          if (cnt_q != CNT_ZERO) begin
            rxd_d = rx_shift;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              rxv_d = 1'b1;
              if (state_q == S_RADD) rdf_d = 1'b1;
            end
          end
        end
        S_RDATA: begin
          unique case (phase_q)
            P_RX: begin
              if (cnt_q != CNT_ZERO) begin
                rxd_d = rx_shift;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                  rxv_d   = 1'b1;
                  phase_d = P_WAIT;
                  to_d    = '0;
                end
              end
            end
            P_WAIT: begin
              if (tx_valid) begin
                miso_d  = LSB_FIRST ?
                          tx_data[0] :
                          tx_data[DATA_W-1];
                sh_d    = LSB_FIRST ?
                          (tx_data >> 1) :
                          (tx_data << 1);
                cnt_d   = CNT_TX;
                phase_d = P_TX;
              end else if (to_q == TO_LAST) begin
                tout_d  = 1'b1;
                rdf_d   = 1'b0;
                phase_d = P_DONE;
              end else begin
                to_d = to_q + TO_ONE;
              end
            end
            P_TX: begin
              if (cnt_q != CNT_ZERO) begin
                miso_d = LSB_FIRST ?
                         sh_q[0] :
                         sh_q[DATA_W-1];
                sh_d   = LSB_FIRST ?
                         (sh_q >> 1) :
                         (sh_q << 1);
                cnt_d  = cnt_q - CNT_ONE;
              end else begin
                rdf_d   = 1'b0;
                phase_d = P_DONE;
              end
            end
            default: begin
            end
          endcase
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= P_RX;
      cnt_q   <= CNT_FULL;
      to_q    <= '0;
      sh_q    <= '0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      miso_q  <= 1'b0;
      ferr_q  <= 1'b0;
      tout_q  <= 1'b0;
      rdf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      sh_q    <= sh_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      miso_q  <= miso_d;
      ferr_q  <= ferr_d;
      tout_q  <= tout_d;
      rdf_q   <= rdf_d;
    end
  end

  assign MISO       = miso_q;
  assign rx_data    = rxd_q;
  assign rx_valid   = rxv_q;
  assign frame_err  = ferr_q;
  assign tx_timeout = tout_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: MSB-first default instance (A)
// and LSB-first, short-timeout instance (B) on shared inputs.
module tb_spi_slave_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       miso_a, rxv_a, busy_a, ferr_a, to_a;
  logic [9:0] rxd_a;
  logic       miso_b, rxv_b, busy_b, ferr_b, to_b;
  logic [9:0] rxd_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_slave_param #(
    .DATA_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(15)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(miso_a),
    .rx_data(rxd_a), .rx_valid(rxv_a),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy_a), .frame_err(ferr_a),
    .tx_timeout(to_a)
  );

  spi_slave_param #(
    .DATA_W(8), .LSB_FIRST(1'b1), .TX_TIMEOUT(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(miso_b),
    .rx_data(rxd_b), .rx_valid(rxv_b),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy_b), .frame_err(ferr_b),
    .tx_timeout(to_b)
  );

  typedef struct {
    logic       ss;
    logic       mosi;
    logic       rxv;
    logic       busy;
    logic       ferr;
    logic [9:0] rxd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ss, input logic mosi,
    input logic rxv, input logic busy,
    input logic ferr, input logic [9:0] rxd
  );
    vec_t v;
    v.ss = ss; v.mosi = mosi; v.rxv = rxv;
    v.busy = busy; v.ferr = ferr; v.rxd = rxd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] f,
                      input bit lsb);
    for (int i = 0; i < 10; i++) begin
      MOSI = lsb ? f[i] : f[9-i];
      tick();
    end
  endtask

  task automatic start(input logic dir);
    SS_n = 1'b0;
    tick();
    MOSI = dir;
    tick();
  endtask

  task automatic stop();
    SS_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    SS_n = 1'b1;
    tx_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic read_seq(input bit b,
                          input logic [7:0] w,
                          input string nm);
    start(1'b1);
    send(10'h207, b);
    chk($sformatf("%s_raddr", nm),
        b ? rxd_b : rxd_a, 10'h207);
    stop();
    start(1'b0);
    send(10'h0FF, b);
    stop();
    start(1'b1);
    send(10'h300, b);
    chk($sformatf("%s_rdrxv", nm),
        b ? rxv_b : rxv_a, 1);
    tx_valid = 1'b1;
    tx_data = w;
    tick();
    tx_data = ~w;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_miso%0d", nm, i),
          b ? miso_b : miso_a,
          b ? w[i] : w[7-i]);
      tick();
    end
    chk($sformatf("%s_misoend", nm),
        b ? miso_b : miso_a, 0);
    tx_valid = 1'b0;
    stop();
  endtask

  task automatic chk_readadd(input bit b,
                             input string nm);
    start(1'b1);
    send(10'h300, b);
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    tick();
    chk($sformatf("%s_ra0", nm),
        b ? miso_b : miso_a, 0);
    tick();
    chk($sformatf("%s_ra1", nm),
        b ? miso_b : miso_a, 0);
    tx_valid = 1'b0;
    stop();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Write-address frame, CHK abort, 4-bit abort.
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 10'h001));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h002));
    tbl.push_back(mk(0, 1, 0, 1, 0, 10'h005));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h00A));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h014));
    tbl.push_back(mk(0, 1, 0, 1, 0, 10'h029));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h052));
    tbl.push_back(mk(0, 1, 1, 1, 0, 10'h0A5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h0A5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 10'h0A5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 10'h000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h000));
    tbl.push_back(mk(1, 0, 0, 0, 0, 10'h000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h000));
    tbl.push_back(mk(0, 1, 0, 1, 0, 10'h001));
    tbl.push_back(mk(0, 1, 0, 1, 0, 10'h003));
    tbl.push_back(mk(0, 0, 0, 1, 0, 10'h006));
    tbl.push_back(mk(0, 1, 0, 1, 0, 10'h00D));
    tbl.push_back(mk(1, 0, 0, 0, 1, 10'h00D));
    tbl.push_back(mk(1, 0, 0, 0, 0, 10'h000));

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_a",
        {busy_a, rxv_a, ferr_a, to_a, miso_a, rxd_a},
        15'h0);
    chk("reset_b",
        {busy_b, rxv_b, ferr_b, to_b, miso_b, rxd_b},
        15'h0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      SS_n = tbl[i].ss;
      MOSI = tbl[i].mosi;
      tick();
      chk($sformatf("vec%0d", i),
          {rxv_a, busy_a, ferr_a, to_a, miso_a, rxd_a},
          {tbl[i].rxv, tbl[i].busy, tbl[i].ferr,
           2'b00, tbl[i].rxd});
    end

    // Abort with DATA_W+1 bits taken.
    start(1'b0);
    for (int i = 0; i < 9; i++) begin
      MOSI = 1'b1;
      tick();
    end
    SS_n = 1'b1;
    tick();
    chk("abort9_ferr", {ferr_a, rxv_a, busy_a}, 3'b100);
    tick();
    chk("abort9_clr", ferr_a, 0);

    // MSB-first read, then rd_flag cleared.
    do_reset();
    read_seq(1'b0, 8'h3C, "msb3c");
    chk_readadd(1'b0, "msb_after");

    // Abort mid-TX keeps rd_flag: retry works.
    start(1'b1);
    send(10'h300, 1'b0);
    tx_valid = 1'b1;
    tx_data = 8'h81;
    tick();
    chk("txab_bit7", miso_a, 1);
    tx_valid = 1'b0;
    tick();
    SS_n = 1'b1;
    tick();
    chk("txab_miso", {miso_a, busy_a, ferr_a}, 3'b000);
    tick();
    start(1'b1);
    send(10'h300, 1'b0);
    tx_valid = 1'b1;
    tick();
    chk("txab_retry", miso_a, 1);
    tx_valid = 1'b0;
    stop();

    // LSB-first instance.
    do_reset();
    start(1'b0);
    send(10'h0A5, 1'b1);
    chk("lsb_rxd", rxd_b, 10'h0A5);
    chk("lsb_rxv", rxv_b, 1);
    stop();
    start(1'b0);
    send(10'h2C1, 1'b1);
    chk("lsb_rxd2", rxd_b, 10'h2C1);
    stop();
    read_seq(1'b1, 8'h3C, "lsb3c");
    read_seq(1'b1, 8'hC5, "lsbc5");

    // Read-response timeout.
    do_reset();
    start(1'b1);
    send(10'h207, 1'b0);
    stop();
    start(1'b1);
    send(10'h300, 1'b0);
    tx_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("to_a_%0d", i), to_a, (i == 15));
      chk($sformatf("to_b_%0d", i), to_b, (i == 4));
    end
    chk("to_state", {miso_a, busy_a, rxv_a}, 3'b010);
    tick();
    chk("to_clr", to_a, 0);
    stop();
    chk_readadd(1'b0, "to_after");

    // Reset mid-write frame.
    do_reset();
    start(1'b0);
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("rst_mid",
        {busy_a, rxv_a, ferr_a, to_a, miso_a, rxd_a},
        15'h0);
    rst_n = 1'b1;
    SS_n = 1'b1;
    tick();
    start(1'b0);
    send(10'h15A, 1'b0);
    chk("rst_after", {rxv_a, rxd_a}, {1'b1, 10'h15A});
    stop();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
